// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush sequencer for the 5-stage pipeline. Merges the load-use
// stall, the EX-stage branch flush and the multi-cycle data-memory handshake
// into per-stage enables and bubble/flush controls. Also runs the post-reset
// fill sequence, a memory-wait watchdog and saturating stall/flush counters.
module pipeline_sequencer #(
   parameter int FILL_CYCLES = 4,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Hazard_Stall,
   input  logic             Branch_Taken,
   input  logic             Mem_Req,
   input  logic             Mem_Ready,
   output logic             PC_En,
   output logic             IFID_En,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EXMEM_En,
   output logic             MEMWB_En,
   output logic             Busy,
   output logic             Mem_Timeout,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count
);

   // Counter widths: fill counter holds 0..FILL_CYCLES-1, wait counter 0..TIMEOUT-1.
   localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   // FSM encoding
   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [FILL_W-1:0] fill_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              timeout_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;

   // Per-cycle action qualifiers
   logic freeze_s;     // full pipeline freeze (memory not ready)
   logic decode_s;     // branch/hazard/normal decode applies this cycle
   logic abort_s;      // watchdog expiry: release without counting a stall
   logic branch_s;
   logic hazard_s;
   logic stall_inc_s;
   logic flush_inc_s;

   // Next-state selection and classification of the current cycle
   always_comb begin
      state_nxt_s = state_r;
      freeze_s    = 1'b0;
      decode_s    = 1'b0;
      abort_s     = 1'b0;
      case (state_r)
         ST_INIT: begin
            if (fill_cnt_r == FILL_LAST) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN: begin
            // A request with Ready in the same cycle is a single-cycle access.
            if (Mem_Req && !Mem_Ready) begin
               freeze_s    = 1'b1;
               state_nxt_s = ST_WAIT;
            end else begin
               decode_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end
         end
         ST_WAIT: begin
            // Mem_Req is don't-care here: the access in flight is still the old one.
            if (Mem_Ready) begin
               decode_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end else if (wait_cnt_r == WAIT_LAST) begin
               decode_s    = 1'b1;
               abort_s     = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               freeze_s    = 1'b1;
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            // Unreachable encoding: recover through the fill sequence.
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // Branch wins over the load-use stall: the ID-stage instruction is wrong-path.
   assign branch_s    = decode_s & Branch_Taken;
   assign hazard_s    = decode_s & ~Branch_Taken & Hazard_Stall;
   assign stall_inc_s = freeze_s | (hazard_s & ~abort_s);
   assign flush_inc_s = branch_s;

   // Stage enables and bubble/flush controls, zero latency from the requests
   always_comb begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      EXMEM_En   = 1'b0;
      MEMWB_En   = 1'b0;
      if (freeze_s) begin
         PC_En      = 1'b0;
      end else if (branch_s) begin
         PC_En      = 1'b1;
         IFID_En    = 1'b1;
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
         EXMEM_En   = 1'b1;
         MEMWB_En   = 1'b1;
      end else if (hazard_s) begin
         IDEX_Flush = 1'b1;
         EXMEM_En   = 1'b1;
         MEMWB_En   = 1'b1;
      end else if (decode_s) begin
         PC_En      = 1'b1;
         IFID_En    = 1'b1;
         EXMEM_En   = 1'b1;
         MEMWB_En   = 1'b1;
      end else begin
         // INIT (or unreachable state): hold everything flushed.
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end
   end

   assign Busy        = (state_r != ST_RUN);
   assign Mem_Timeout = timeout_r;
   assign Stall_Count = stall_cnt_r;
   assign Flush_Count = flush_cnt_r;

   // State register plus fill and memory-wait counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_INIT;
         fill_cnt_r <= {FILL_W{1'b0}};
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_INIT) begin
            fill_cnt_r <= fill_cnt_r + FILL_W'(1);
         end else begin
            fill_cnt_r <= {FILL_W{1'b0}};
         end
         if (state_r == ST_RUN) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
         end else if (freeze_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // Sticky watchdog flag and saturating performance counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         timeout_r   <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         timeout_r <= timeout_r | abort_s;
         if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Scenario tasks drive one stimulus vector per cycle (just after the rising
// edge), push the expected stage-control vector to a queue, and pop/compare it
// at the falling edge. Counter and flag values are checked inline.
module tb_pipeline_sequencer;

   logic       Clk;
   logic       Reset;
   logic       Hazard_Stall;
   logic       Branch_Taken;
   logic       Mem_Req;
   logic       Mem_Ready;
   logic       PC_En;
   logic       IFID_En;
   logic       IFID_Flush;
   logic       IDEX_Flush;
   logic       EXMEM_En;
   logic       MEMWB_En;
   logic       Busy;
   logic       Mem_Timeout;
   logic [2:0] Stall_Count;
   logic [2:0] Flush_Count;

   int n_cmp = 0;
   int n_err = 0;

   logic [6:0] exp_q[$];
   logic [6:0] outs;

   // {PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_En, MEMWB_En, Busy}
   localparam logic [6:0] O_INIT  = 7'b0011001;
   localparam logic [6:0] O_RUN   = 7'b1100110;
   localparam logic [6:0] O_RUNW  = 7'b1100111;  // normal decode while leaving MEM_WAIT
   localparam logic [6:0] O_FRZR  = 7'b0000000;  // freeze issued from RUN
   localparam logic [6:0] O_FRZW  = 7'b0000001;  // freeze inside MEM_WAIT
   localparam logic [6:0] O_BR    = 7'b1111110;
   localparam logic [6:0] O_HZ    = 7'b0001110;

   assign outs = {PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_En, MEMWB_En, Busy};

   pipeline_sequencer #(
      .FILL_CYCLES(4),
      .TIMEOUT    (4),
      .CNT_W      (3)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Hazard_Stall(Hazard_Stall),
      .Branch_Taken(Branch_Taken),
      .Mem_Req     (Mem_Req),
      .Mem_Ready   (Mem_Ready),
      .PC_En       (PC_En),
      .IFID_En     (IFID_En),
      .IFID_Flush  (IFID_Flush),
      .IDEX_Flush  (IDEX_Flush),
      .EXMEM_En    (EXMEM_En),
      .MEMWB_En    (MEMWB_En),
      .Busy        (Busy),
      .Mem_Timeout (Mem_Timeout),
      .Stall_Count (Stall_Count),
      .Flush_Count (Flush_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // stim = {Hazard_Stall, Branch_Taken, Mem_Req, Mem_Ready}
   task automatic apply(input logic [3:0] s, input logic [6:0] e);
      {Hazard_Stall, Branch_Taken, Mem_Req, Mem_Ready} = s;
      exp_q.push_back(e);
   endtask

   // Assert Reset for two edges and release it just after a rising edge.
   task automatic do_reset();
      @(posedge Clk); #1;
      Reset = 1'b1;
      {Hazard_Stall, Branch_Taken, Mem_Req, Mem_Ready} = 4'b0000;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   // Reset plus the four fill cycles; returns at the start of the first RUN cycle.
   task automatic fill();
      do_reset();
      repeat (4) @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      logic [6:0] ex [0:4];
      ex = '{O_INIT, O_INIT, O_INIT, O_INIT, O_RUN};
      @(posedge Clk); #1;
      Reset = 1'b1;
      {Hazard_Stall, Branch_Taken, Mem_Req, Mem_Ready} = 4'b0000;
      #2;
      n_cmp++;
      if (outs !== O_INIT || Stall_Count !== 3'd0 || Flush_Count !== 3'd0 || Mem_Timeout !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold got outs=%b st=%0d fl=%0d to=%b exp outs=%b st=0 fl=0 to=0",
                  outs, Stall_Count, Flush_Count, Mem_Timeout, O_INIT);
      end
      @(posedge Clk); #1 Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply(4'b0000, ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL reset_fill cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd0 || Flush_Count !== 3'd0) begin
         n_err++;
         $display("FAIL reset_counters got st=%0d fl=%0d exp 0/0", Stall_Count, Flush_Count);
      end
   endtask

   task automatic test_load_use();
      logic [6:0] e;
      logic [3:0] st [0:1];
      logic [6:0] ex [0:1];
      st = '{4'b1000, 4'b0000};
      ex = '{O_HZ, O_RUN};
      fill();
      for (int i = 0; i < 2; i++) begin
         apply(st[i], ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL load_use cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd1 || Flush_Count !== 3'd0) begin
         n_err++;
         $display("FAIL load_use_cnt got st=%0d fl=%0d exp 1/0", Stall_Count, Flush_Count);
      end
   endtask

   task automatic test_branch_stall();
      logic [6:0] e;
      logic [3:0] st [0:1];
      logic [6:0] ex [0:1];
      st = '{4'b1100, 4'b0000};
      ex = '{O_BR, O_RUN};
      fill();
      for (int i = 0; i < 2; i++) begin
         apply(st[i], ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL branch_stall cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd0 || Flush_Count !== 3'd1) begin
         n_err++;
         $display("FAIL branch_stall_cnt got st=%0d fl=%0d exp 0/1", Stall_Count, Flush_Count);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e;
      logic [3:0] st [0:3];
      logic [6:0] ex [0:3];
      st = '{4'b1000, 4'b0100, 4'b1000, 4'b0000};
      ex = '{O_HZ, O_BR, O_HZ, O_RUN};
      fill();
      for (int i = 0; i < 4; i++) begin
         apply(st[i], ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL back_to_back cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd2 || Flush_Count !== 3'd1) begin
         n_err++;
         $display("FAIL back_to_back_cnt got st=%0d fl=%0d exp 2/1", Stall_Count, Flush_Count);
      end
   endtask

   // Two-cycle freeze, release on Ready, then single-cycle accesses (incl. with branch).
   task automatic test_mem_miss();
      logic [6:0] e;
      logic [3:0] st [0:5];
      logic [6:0] ex [0:5];
      st = '{4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0111, 4'b0000};
      ex = '{O_FRZR, O_FRZW, O_RUNW, O_RUN, O_BR, O_RUN};
      fill();
      for (int i = 0; i < 6; i++) begin
         apply(st[i], ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL mem_miss cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd2 || Flush_Count !== 3'd1 || Mem_Timeout !== 1'b0) begin
         n_err++;
         $display("FAIL mem_miss_cnt got st=%0d fl=%0d to=%b exp 2/1/0", Stall_Count, Flush_Count, Mem_Timeout);
      end
   endtask

   // Stuck memory: 4 freeze cycles (branch/hazard ignored), abort release, sticky flag,
   // then a second miss interrupted by Reset.
   task automatic test_watchdog();
      logic [6:0] e;
      logic [3:0] st [0:6];
      logic [6:0] ex [0:6];
      logic [6:0] ex2 [0:4];
      st  = '{4'b0010, 4'b0110, 4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      ex  = '{O_FRZR, O_FRZW, O_FRZW, O_FRZW, O_RUNW, O_RUN, O_RUN};
      ex2 = '{O_INIT, O_INIT, O_INIT, O_INIT, O_RUN};
      fill();
      for (int i = 0; i < 7; i++) begin
         apply(st[i], ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL watchdog cyc%0d got %b exp %b", i, outs, e);
         end
         n_cmp++;
         if (Mem_Timeout !== (i >= 5)) begin
            n_err++;
            $display("FAIL watchdog_flag cyc%0d got %b exp %b", i, Mem_Timeout, (i >= 5));
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd4 || Flush_Count !== 3'd0) begin
         n_err++;
         $display("FAIL watchdog_cnt got st=%0d fl=%0d exp 4/0", Stall_Count, Flush_Count);
      end
      // Second miss, Reset asserted while in MEM_WAIT.
      for (int i = 0; i < 2; i++) begin
         apply(4'b0010, (i == 0) ? O_FRZR : O_FRZW);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL watchdog_miss2 cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
      Reset = 1'b1;
      apply(4'b0000, O_INIT);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e || Mem_Timeout !== 1'b0 || Stall_Count !== 3'd0) begin
         n_err++;
         $display("FAIL watchdog_reset got outs=%b to=%b st=%0d exp outs=%b to=0 st=0",
                  outs, Mem_Timeout, Stall_Count, e);
      end
      @(posedge Clk); #1 Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply(4'b0000, ex2[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin
            n_err++;
            $display("FAIL watchdog_refill cyc%0d got %b exp %b", i, outs, e);
         end
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_saturation();
      logic [6:0] e;
      logic [2:0] exp_cnt;
      fill();
      for (int i = 0; i < 10; i++) begin
         apply((i < 9) ? 4'b1000 : 4'b0000, (i < 9) ? O_HZ : O_RUN);
         @(negedge Clk);
         e = exp_q.pop_front();
         exp_cnt = (i < 7) ? 3'(i) : 3'd7;
         n_cmp++;
         if (outs !== e || Stall_Count !== exp_cnt) begin
            n_err++;
            $display("FAIL saturation cyc%0d got outs=%b st=%0d exp outs=%b st=%0d",
                     i, outs, Stall_Count, e, exp_cnt);
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (Stall_Count !== 3'd7) begin
         n_err++;
         $display("FAIL saturation_final got %0d exp 7", Stall_Count);
      end
   endtask

   initial begin
      Reset = 1'b1;
      {Hazard_Stall, Branch_Taken, Mem_Req, Mem_Ready} = 4'b0000;
      test_reset();
      test_load_use();
      test_branch_stall();
      test_back_to_back();
      test_mem_miss();
      test_watchdog();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
